// File: rtl/wb_arbiter_if.sv
`default_nettype none
//============================================================================
// Module      : wb_arbiter_if
// Description : Bundle of the write-back request and result signals between
//               the three producers (MUL stage 4/5, load return, ALU) and the
//               register-file write port.
//               Signal suffixes are given from the arbiter's point of view:
//               *_i are driven by the producers, *_o by the arbiter.
// Modports    : slave  - the arbiter (consumes requests, drives write port)
//               master - the pipeline side (drives requests, observes port)
// Ports       : ex4_valid_i                    MUL stage 4 valid
//               ex5_valid_i/_wr_reg_i/_result_i MUL result (no back-pressure)
//               mem_valid_i/_ready_o/_wr_reg_i/_data_i  load return
//               alu_valid_i/_ready_o/_wr_reg_i/_data_i  ALU result
//               wb_reg_wr_en_o, wb_wr_reg_o, wb_data_o, wb_src_o  write port
//               mul_wb_next_o, mul_throttle_o   decode-side hints
// Revision    : 1.0 - initial release
//============================================================================
interface wb_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5
);
    // MUL pipeline
    logic                      ex4_valid_i;
    logic                      ex5_valid_i;
    logic [REGISTER_WIDTH-1:0] ex5_wr_reg_i;
    logic [DATA_WIDTH-1:0]     ex5_result_i;

    // Load return
    logic                      mem_valid_i;
    logic                      mem_ready_o;
    logic [REGISTER_WIDTH-1:0] mem_wr_reg_i;
    logic [DATA_WIDTH-1:0]     mem_data_i;

    // ALU result
    logic                      alu_valid_i;
    logic                      alu_ready_o;
    logic [REGISTER_WIDTH-1:0] alu_wr_reg_i;
    logic [DATA_WIDTH-1:0]     alu_data_i;

    // Register-file write port and decode hints
    logic                      wb_reg_wr_en_o;
    logic [REGISTER_WIDTH-1:0] wb_wr_reg_o;
    logic [DATA_WIDTH-1:0]     wb_data_o;
    logic [1:0]                wb_src_o;
    logic                      mul_wb_next_o;
    logic                      mul_throttle_o;

    modport slave (
        input  ex4_valid_i, ex5_valid_i, ex5_wr_reg_i, ex5_result_i,
        input  mem_valid_i, mem_wr_reg_i, mem_data_i,
        input  alu_valid_i, alu_wr_reg_i, alu_data_i,
        output mem_ready_o, alu_ready_o,
        output wb_reg_wr_en_o, wb_wr_reg_o, wb_data_o, wb_src_o,
        output mul_wb_next_o, mul_throttle_o
    );

    modport master (
        output ex4_valid_i, ex5_valid_i, ex5_wr_reg_i, ex5_result_i,
        output mem_valid_i, mem_wr_reg_i, mem_data_i,
        output alu_valid_i, alu_wr_reg_i, alu_data_i,
        input  mem_ready_o, alu_ready_o,
        input  wb_reg_wr_en_o, wb_wr_reg_o, wb_data_o, wb_src_o,
        input  mul_wb_next_o, mul_throttle_o
    );
endinterface : wb_arbiter_if
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
//============================================================================
// Module      : wb_arbiter
// Description : Single-port register-file write-back arbiter.
//               MUL results (stage 5) cannot stall and always win. Load
//               returns and ALU results share the remaining slots with a
//               1-bit round-robin pointer. The winner's payload is
//               registered onto the write port one cycle later. A
//               saturating starve counter raises mul_throttle_o so decode
//               stops issuing MULs when they keep blocking MEM/ALU.
// Ports       : clk_i  - clock, rising edge
//               rst_i  - asynchronous reset, active low
//               bus    - wb_arbiter_if.slave (requests in, write port out)
// Revision    : 1.0 - initial release
//============================================================================
module wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5,
    parameter int STARVE_LIMIT   = 4    // legal range 1..15
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    wb_arbiter_if.slave bus
);

    // Write-port source codes
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_MUL  = 2'd1;
    localparam logic [1:0] SRC_MEM  = 2'd2;
    localparam logic [1:0] SRC_ALU  = 2'd3;

    // Round-robin pointer: which of MEM/ALU was granted most recently
    localparam logic RR_MEM = 1'b0;
    localparam logic RR_ALU = 1'b1;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                      run_q;          // low for the first edge after reset
    logic                      last_rr_q,   last_rr_d;
    logic [3:0]                starve_q,    starve_d;
    logic                      throttle_q,  throttle_d;
    logic                      wr_en_q,     wr_en_d;
    logic [1:0]                src_q,       src_d;
    logic [REGISTER_WIDTH-1:0] wr_reg_q,    wr_reg_d;
    logic [DATA_WIDTH-1:0]     data_q,      data_d;

    // ------------------------------------------------------------------
    // Combinational grant
    // ------------------------------------------------------------------
    logic                      grant_mul;
    logic                      grant_mem;
    logic                      grant_alu;
    logic                      grant_any;
    logic                      rr_pending;
    logic [REGISTER_WIDTH-1:0] sel_reg;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic [1:0]                sel_src;

    // run_q is cleared asynchronously by reset, so every grant (and both
    // ready outputs) drops the moment reset asserts, and a request that was
    // waiting when reset hit is never transferred.
    always_comb begin
        grant_mul = 1'b0;
        grant_mem = 1'b0;
        grant_alu = 1'b0;
        if (run_q) begin
            if (bus.ex5_valid_i) begin
                grant_mul = 1'b1;
            end else if (bus.mem_valid_i && bus.alu_valid_i) begin
                // Tie: serve whichever was not granted last
                if (last_rr_q == RR_ALU) begin
                    grant_mem = 1'b1;
                end else begin
                    grant_alu = 1'b1;
                end
            end else if (bus.mem_valid_i) begin
                grant_mem = 1'b1;
            end else if (bus.alu_valid_i) begin
                grant_alu = 1'b1;
            end
        end
    end

    assign grant_any  = grant_mul | grant_mem | grant_alu;
    assign rr_pending = bus.mem_valid_i | bus.alu_valid_i;

    // Payload of the winner
    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        sel_src  = SRC_NONE;
        if (grant_mul) begin
            sel_reg  = bus.ex5_wr_reg_i;
            sel_data = bus.ex5_result_i;
            sel_src  = SRC_MUL;
        end else if (grant_mem) begin
            sel_reg  = bus.mem_wr_reg_i;
            sel_data = bus.mem_data_i;
            sel_src  = SRC_MEM;
        end else if (grant_alu) begin
            sel_reg  = bus.alu_wr_reg_i;
            sel_data = bus.alu_data_i;
            sel_src  = SRC_ALU;
        end
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_en_d   = 1'b0;
        src_d     = SRC_NONE;
        wr_reg_d  = wr_reg_q;   // index/data hold on idle cycles
        data_d    = data_q;
        last_rr_d = last_rr_q;
        starve_d  = starve_q;

        if (grant_any) begin
            wr_reg_d = sel_reg;
            data_d   = sel_data;
            src_d    = sel_src;
            // x0 is hard-wired zero: the slot is consumed but nothing is written
            wr_en_d  = (sel_reg != '0);
        end

        // MUL grants leave the round-robin pointer alone
        if (grant_mem) begin
            last_rr_d = RR_MEM;
        end else if (grant_alu) begin
            last_rr_d = RR_ALU;
        end

        if (grant_mul && rr_pending) begin
            if (starve_q < STARVE_LIM) begin
                starve_d = starve_q + 4'd1;
            end
        end else if (grant_mem || grant_alu || !rr_pending) begin
            starve_d = 4'd0;
        end

        // Registered from the next counter value so throttle rises in the
        // same cycle the counter reaches the limit.
        throttle_d = (starve_d >= STARVE_LIM);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            run_q      <= 1'b0;
            last_rr_q  <= RR_ALU;   // MEM wins the first tie
            starve_q   <= 4'd0;
            throttle_q <= 1'b0;
            wr_en_q    <= 1'b0;
            src_q      <= SRC_NONE;
            wr_reg_q   <= '0;
            data_q     <= '0;
        end else begin
            run_q      <= 1'b1;
            last_rr_q  <= last_rr_d;
            starve_q   <= starve_d;
            throttle_q <= throttle_d;
            wr_en_q    <= wr_en_d;
            src_q      <= src_d;
            wr_reg_q   <= wr_reg_d;
            data_q     <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_ready_o    = grant_mem;
    assign bus.alu_ready_o    = grant_alu;
    assign bus.wb_reg_wr_en_o = wr_en_q;
    assign bus.wb_src_o       = src_q;
    assign bus.wb_wr_reg_o    = wr_reg_q;
    assign bus.wb_data_o      = data_q;
    assign bus.mul_wb_next_o  = bus.ex4_valid_i;
    assign bus.mul_throttle_o = throttle_q;

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter. A table of cycle
//               vectors (inputs, expected ready/hint outputs and expected
//               registered write port one cycle later) is applied in order;
//               expected write-port values are queued when a vector is
//               driven and popped after the following clock edge. Extra
//               sequences cover starvation throttle and mid-stream reset.
// Revision    : 1.0 - initial release
//============================================================================
module tb_wb_arbiter;

    localparam int DW = 32;
    localparam int RW = 5;

    logic clk;
    logic rst_n;

    wb_arbiter_if #(.DATA_WIDTH(DW), .REGISTER_WIDTH(RW)) bus ();

    wb_arbiter #(
        .DATA_WIDTH    (DW),
        .REGISTER_WIDTH(RW),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ex4_v;
        logic          ex5_v;
        logic [RW-1:0] ex5_reg;
        logic [DW-1:0] ex5_res;
        logic          mem_v;
        logic [RW-1:0] mem_reg;
        logic [DW-1:0] mem_data;
        logic          alu_v;
        logic [RW-1:0] alu_reg;
        logic [DW-1:0] alu_data;
        // expected same-cycle outputs
        logic          x_mem_rdy;
        logic          x_alu_rdy;
        logic          x_next;
        // expected write port after the edge
        logic          x_en;
        logic [1:0]    x_src;
        logic [RW-1:0] x_reg;
        logic [DW-1:0] x_data;
        logic          x_thr;
    } vec_t;

    typedef struct {
        logic          en;
        logic [1:0]    src;
        logic [RW-1:0] rg;
        logic [DW-1:0] data;
        logic          thr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic ex4_v, input logic ex5_v, input logic [RW-1:0] ex5_reg, input logic [DW-1:0] ex5_res,
        input logic mem_v, input logic [RW-1:0] mem_reg, input logic [DW-1:0] mem_data,
        input logic alu_v, input logic [RW-1:0] alu_reg, input logic [DW-1:0] alu_data,
        input logic x_mem_rdy, input logic x_alu_rdy, input logic x_next,
        input logic x_en, input logic [1:0] x_src, input logic [RW-1:0] x_reg,
        input logic [DW-1:0] x_data, input logic x_thr);
        vec_t v;
        v.ex4_v = ex4_v;  v.ex5_v = ex5_v;  v.ex5_reg = ex5_reg;  v.ex5_res = ex5_res;
        v.mem_v = mem_v;  v.mem_reg = mem_reg;  v.mem_data = mem_data;
        v.alu_v = alu_v;  v.alu_reg = alu_reg;  v.alu_data = alu_data;
        v.x_mem_rdy = x_mem_rdy;  v.x_alu_rdy = x_alu_rdy;  v.x_next = x_next;
        v.x_en = x_en;  v.x_src = x_src;  v.x_reg = x_reg;  v.x_data = x_data;  v.x_thr = x_thr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.ex4_valid_i  = v.ex4_v;
        bus.ex5_valid_i  = v.ex5_v;
        bus.ex5_wr_reg_i = v.ex5_reg;
        bus.ex5_result_i = v.ex5_res;
        bus.mem_valid_i  = v.mem_v;
        bus.mem_wr_reg_i = v.mem_reg;
        bus.mem_data_i   = v.mem_data;
        bus.alu_valid_i  = v.alu_v;
        bus.alu_wr_reg_i = v.alu_reg;
        bus.alu_data_i   = v.alu_data;
    endtask

    // Drive on the falling edge, check combinational outputs mid-cycle,
    // queue the expected write port, pop and compare just after the edge.
    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, ".mem_ready"},   64'(bus.mem_ready_o),   64'(v.x_mem_rdy));
        chk({tag, ".alu_ready"},   64'(bus.alu_ready_o),   64'(v.x_alu_rdy));
        chk({tag, ".mul_wb_next"}, 64'(bus.mul_wb_next_o), 64'(v.x_next));
        e.en = v.x_en;  e.src = v.x_src;  e.rg = v.x_reg;  e.data = v.x_data;  e.thr = v.x_thr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".wr_en"},    64'(bus.wb_reg_wr_en_o), 64'(got.en));
        chk({tag, ".src"},      64'(bus.wb_src_o),       64'(got.src));
        chk({tag, ".wr_reg"},   64'(bus.wb_wr_reg_o),    64'(got.rg));
        chk({tag, ".data"},     64'(bus.wb_data_o),      64'(got.data));
        chk({tag, ".throttle"}, 64'(bus.mul_throttle_o), 64'(got.thr));
    endtask

    task automatic chk_port_zero(input string tag);
        chk({tag, ".wr_en"},     64'(bus.wb_reg_wr_en_o), 64'd0);
        chk({tag, ".src"},       64'(bus.wb_src_o),       64'd0);
        chk({tag, ".wr_reg"},    64'(bus.wb_wr_reg_o),    64'd0);
        chk({tag, ".data"},      64'(bus.wb_data_o),      64'd0);
        chk({tag, ".throttle"},  64'(bus.mul_throttle_o), 64'd0);
        chk({tag, ".mem_ready"}, 64'(bus.mem_ready_o),    64'd0);
        chk({tag, ".alu_ready"}, 64'(bus.alu_ready_o),    64'd0);
    endtask

    vec_t tbl[15];
    vec_t idle;

    initial begin
        //              ex4 ex5 rd  res          mem rd  data         alu rd  data          mrdy ardy nxt  en src    rd  data          thr
        tbl[0]  = mk(0, 0, 0,  0,            1, 3,  32'h11,       1, 4,  32'h22,        1, 0, 0,  1, 2'd2, 3,  32'h11,       0);
        tbl[1]  = mk(0, 0, 0,  0,            0, 0,  0,            1, 4,  32'h22,        0, 1, 0,  1, 2'd3, 4,  32'h22,       0);
        tbl[2]  = mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,             0, 0, 0,  0, 2'd0, 4,  32'h22,       0);
        tbl[3]  = mk(0, 1, 7,  32'hAA,       0, 0,  0,            1, 5,  32'h55,        0, 0, 0,  1, 2'd1, 7,  32'hAA,       0);
        tbl[4]  = mk(0, 0, 0,  0,            0, 0,  0,            1, 5,  32'h55,        0, 1, 0,  1, 2'd3, 5,  32'h55,       0);
        tbl[5]  = mk(0, 0, 0,  0,            0, 0,  0,            1, 0,  32'hDEADBEEF,  0, 1, 0,  0, 2'd3, 0,  32'hDEADBEEF, 0);
        tbl[6]  = mk(0, 0, 0,  0,            1, 8,  32'h88,       1, 9,  32'h99,        1, 0, 0,  1, 2'd2, 8,  32'h88,       0);
        tbl[7]  = mk(0, 0, 0,  0,            1, 10, 32'hA0,       1, 9,  32'h99,        0, 1, 0,  1, 2'd3, 9,  32'h99,       0);
        tbl[8]  = mk(0, 0, 0,  0,            1, 10, 32'hA0,       0, 0,  0,             1, 0, 0,  1, 2'd2, 10, 32'hA0,       0);
        tbl[9]  = mk(1, 0, 0,  0,            0, 0,  0,            0, 0,  0,             0, 0, 1,  0, 2'd0, 10, 32'hA0,       0);
        tbl[10] = mk(0, 1, 12, 32'hC0,       0, 0,  0,            0, 0,  0,             0, 0, 0,  1, 2'd1, 12, 32'hC0,       0);
        tbl[11] = mk(0, 0, 0,  0,            1, 13, 32'hD0,       1, 14, 32'hE0,        0, 1, 0,  1, 2'd3, 14, 32'hE0,       0);
        tbl[12] = mk(0, 0, 0,  0,            1, 13, 32'hD0,       0, 0,  0,             1, 0, 0,  1, 2'd2, 13, 32'hD0,       0);
        tbl[13] = mk(0, 1, 0,  32'h77,       0, 0,  0,            0, 0,  0,             0, 0, 0,  0, 2'd1, 0,  32'h77,       0);
        tbl[14] = mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,             0, 0, 0,  0, 2'd0, 0,  32'h77,       0);

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);

        // Reset state
        rst_n = 1'b0;
        drive(idle);
        #1;
        chk_port_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset.wr_en", 64'(bus.wb_reg_wr_en_o), 64'd0);

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Starvation: four MUL cycles with MEM waiting raise throttle
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("starve%0d", i),
                  mk(0, 1, 5'(16 + i), 32'(32'h100 + i), 1, 2, 32'h2222, 0, 0, 0,
                     0, 0, 0, 1, 2'd1, 5'(16 + i), 32'(32'h100 + i), (i >= 3)));
        end
        // MEM finally granted: throttle clears the cycle after
        apply("starve_mem", mk(0, 0, 0, 0, 1, 2, 32'h2222, 0, 0, 0,
                               1, 0, 0, 1, 2'd2, 2, 32'h2222, 0));
        // Throttle does not block an in-flight MUL result
        apply("starve_mul_after", mk(1, 1, 6, 32'h6, 0, 0, 0, 0, 0, 0,
                                     0, 0, 1, 1, 2'd1, 6, 32'h6, 0));

        // Mid-stream reset: leave pointer at MEM, then reset while writing
        apply("pre_rst", mk(0, 0, 0, 0, 1, 6, 32'h66, 0, 0, 0,
                            1, 0, 0, 1, 2'd2, 6, 32'h66, 0));
        drive(mk(0, 0, 0, 0, 1, 11, 32'hBB, 1, 15, 32'hCC,
                 0, 0, 0, 0, 2'd0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk_port_zero("async_rst");
        @(posedge clk);
        #1;
        chk_port_zero("in_rst");
        @(negedge clk);
        drive(idle);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release.wr_en", 64'(bus.wb_reg_wr_en_o), 64'd0);
        // Pointer back to ALU after reset, so MEM wins this tie
        apply("post_rst_tie0", mk(0, 0, 0, 0, 1, 11, 32'hBB, 1, 15, 32'hCC,
                                  1, 0, 0, 1, 2'd2, 11, 32'hBB, 0));
        apply("post_rst_tie1", mk(0, 0, 0, 0, 0, 0, 0, 1, 15, 32'hCC,
                                  0, 1, 0, 1, 2'd3, 15, 32'hCC, 0));
        apply("final_idle", idle_with_hold(15, 32'hCC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic vec_t idle_with_hold(input logic [RW-1:0] rg, input logic [DW-1:0] d);
        vec_t v;
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, rg, d, 0);
        return v;
    endfunction

endmodule : tb_wb_arbiter
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default params_pkg::DATA_WIDTH (32), width of write-back data.
REQ-002 Parameter REGISTER_WIDTH, default params_pkg::REGISTER_WIDTH (5), width of register index.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive MUL-blocked cycles before throttle asserts; legal range 1..15.
REQ-004 clk_i  in  1  single clock; all flops on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-low reset.
REQ-006 ex4_valid_i  in  1  MUL pipeline stage 4 holds a valid instruction.
REQ-007 ex5_valid_i  in  1  MUL result present this cycle; cannot be back-pressured.
REQ-008 ex5_wr_reg_i  in  REGISTER_WIDTH  MUL destination register.
REQ-009 ex5_result_i  in  DATA_WIDTH  MUL result.
REQ-010 mem_valid_i / mem_ready_o  in / out  1 / 1  load-return handshake.
REQ-011 mem_wr_reg_i / mem_data_i  in  REGISTER_WIDTH / DATA_WIDTH  load destination and data.
REQ-012 alu_valid_i / alu_ready_o  in / out  1 / 1  ALU result handshake.
REQ-013 alu_wr_reg_i / alu_data_i  in  REGISTER_WIDTH / DATA_WIDTH  ALU destination and data.
REQ-014 wb_reg_wr_en_o  out  1  register-file write enable (registered).
REQ-015 wb_wr_reg_o / wb_data_o  out  REGISTER_WIDTH / DATA_WIDTH  registered write index and data.
REQ-016 wb_src_o  out  2  registered source of current write: 0 none, 1 MUL, 2 MEM, 3 ALU.
REQ-017 mul_wb_next_o  out  1  MUL will occupy the write port next cycle (feeds decode wb_is_next_cycle).
REQ-018 mul_throttle_o  out  1  registered; decode SHALL NOT issue a new MUL while high.

Function
REQ-019 Grant is combinational each cycle; exactly zero or one source granted.
REQ-020 ex5_valid_i=1 SHALL grant MUL unconditionally; mem_ready_o=alu_ready_o=0 that cycle.
REQ-021 Without MUL: only one of MEM/ALU valid -> grant it; both valid -> grant the one not granted most recently (round-robin).
REQ-022 Round-robin pointer last_rr (1 bit) updates only on a MEM or ALU grant; MUL grants leave it unchanged.
REQ-023 ready_o equals grant for that requester; transfer occurs when valid & ready; requester holds valid and payload stable until transfer.
REQ-024 Cycle after any grant: wb_wr_reg_o, wb_data_o load granted payload; wb_src_o loads source code; wb_reg_wr_en_o = (granted wr_reg != 0).
REQ-025 Write to x0 consumes the handshake and updates wb_src_o/wb_wr_reg_o but SHALL keep wb_reg_wr_en_o=0.
REQ-026 Cycle with no grant: wb_reg_wr_en_o=0, wb_src_o=0; wb_wr_reg_o and wb_data_o hold prior values.
REQ-027 Latency: granted request to wb_reg_wr_en_o exactly 1 cycle; back-to-back grants sustain one write per cycle.
REQ-028 mul_wb_next_o = ex4_valid_i (combinational).
REQ-029 4-bit starve counter: increments (saturating at STARVE_LIMIT) each cycle MUL is granted while mem_valid_i or alu_valid_i is high.
REQ-030 Counter clears to 0 on any MEM/ALU grant, or on a cycle with neither mem_valid_i nor alu_valid_i high.
REQ-031 mul_throttle_o = registered (counter >= STARVE_LIMIT); deasserts the cycle after counter clears.
REQ-032 Throttle does not block in-flight MUL results; they still win per REQ-020.

Reset
REQ-033 rst_i low SHALL asynchronously force wb_reg_wr_en_o=0, wb_src_o=0, wb_wr_reg_o=0, wb_data_o=0, last_rr=ALU (MEM wins first tie), starve counter=0, mul_throttle_o=0.
REQ-034 While rst_i low, mem_ready_o=alu_ready_o=0; reset mid-transfer discards the pending request with no write.
REQ-035 Deassertion takes effect at the next rising clk_i edge; no write issues in the first cycle after reset.

Verification
REQ-036 MEM and ALU valid simultaneously after reset, rd=3/4, no MUL -> MEM granted cycle 0, ALU cycle 1; writes rd=3 then rd=4 on consecutive cycles, wb_src_o 2 then 3.
REQ-037 ex5_valid_i=1 rd=7 data 0x0000_00AA with alu_valid_i=1 -> alu_ready_o=0; next cycle wb_wr_reg_o=7, wb_data_o=0xAA, wb_src_o=1; ALU written the following cycle.
REQ-038 ALU valid rd=0 data 0xDEAD_BEEF -> alu_ready_o=1, next cycle wb_reg_wr_en_o=0, wb_src_o=3.
REQ-039 ex5_valid_i high 4 consecutive cycles with mem_valid_i held high, STARVE_LIMIT=4 -> mul_throttle_o=1 the cycle after the 4th; clears one cycle after MEM granted.
REQ-040 ex4_valid_i pulse -> mul_wb_next_o high same cycle; ex5_valid_i next cycle wins port.
REQ-041 Assert rst_i low mid-stream with wb_reg_wr_en_o=1 -> outputs zero immediately without clock edge; first grant after release follows REQ-033 priority.
